pic_cpu_master: RTL and testbench

Host-side bus initiator for the 8259 PIC CPU port. It drives the chip-select, read/write strobe, A0 and data lines that the PIC read/write control logic decodes. It turns single-beat requests into correctly timed PIC bus cycles, and it expands an INIT request into the ICW1→ICW2→[ICW3]→[ICW4] sequence the PIC expects. It sits between a CPU/testbench model and the PIC top level. The top level resolves the tri-state D bus from d_out/d_oe.

---
 rtl/pic_pkg.sv | 61 ++++++
 rtl/pic_bus_cycle.sv | 118 +++++++++++
 rtl/pic_cpu_master.sv | 218 +++++++++++++++++++++
 tb/tb_pic_cpu_master.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared definitions for the 8259 PIC CPU-port bus initiator.
//   - request op encodings carried on req_op
//   - ICW1 bit positions used when expanding an INIT request
//   - bus-phase state enum (pic_bus_cycle) and sequencer state enum (top)
//   - helpers that walk the ICW1..ICW4 access list
package pic_pkg;

  localparam logic [2:0] OP_INIT  = 3'b000;
  localparam logic [2:0] OP_WR_A1 = 3'b001;
  localparam logic [2:0] OP_WR_A0 = 3'b010;
  localparam logic [2:0] OP_RD_A0 = 3'b011;
  localparam logic [2:0] OP_RD_A1 = 3'b100;

  localparam int IC4       = 0;
  localparam int SNGL      = 1;
  localparam int ICW1_FLAG = 4;

  // Phases of one timed PIC access.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } pic_state_t;

  // Request-level sequencer states.
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_ERR  = 2'd2
  } seq_state_t;

  // INIT access indices: 0=ICW1, 1=ICW2, 2=ICW3, 3=ICW4.
  // True when another ICW follows access idx.
  function automatic logic init_has_next(input logic [1:0] idx,
                                         input logic sngl,
                                         input logic ic4);
    logic r;
    case (idx)
      2'd0:    r = 1'b1;
      2'd1:    r = !sngl || ic4;
      2'd2:    r = ic4;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Index of the ICW that follows access idx (ICW3 skipped in single mode).
  function automatic logic [1:0] init_next_idx(input logic [1:0] idx,
                                               input logic sngl);
    logic [1:0] r;
    case (idx)
      2'd0:    r = 2'd1;
      2'd1:    r = sngl ? 2'd3 : 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// pic_bus_cycle: performs one timed PIC CPU-port access.
//   clk, rst_n      clock, synchronous active-low reset
//   start           launch an access (accepted in IDLE or RECOVER)
//   is_read, a0     access direction and address, sampled with start
//   data            write byte, sampled with start
//   d_in            read data from the bus
//   cs_n/wr_n/rd_n  registered bus strobes
//   bus_a0, d_out   registered address and write data
//   d_oe            registered data-bus drive enable
//   done            high during the last HOLD cycle (RECOVER follows)
//   rd_data         byte captured at the end of the read strobe
//   phase           current phase (pic_state_t encoding)
module pic_bus_cycle
  import pic_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       is_read,
  input  logic       a0,
  input  logic [7:0] data,
  input  logic [7:0] d_in,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       bus_a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       done,
  output logic [7:0] rd_data,
  output logic [2:0] phase
);

  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC = (STROBE_CYC > MAX_SH) ? STROBE_CYC : MAX_SH;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The counter holds "cycles left in this phase minus one" and is
  // reloaded on every phase change, so it only ever counts down to zero.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  pic_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             rd_q;

  assign phase = state;
  assign done  = (state == ST_HOLD) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      bus_a0  <= 1'b0;
      d_out   <= '0;
      d_oe    <= 1'b0;
      rd_q    <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RECOVER: begin
          if (start) begin
            state  <= ST_SETUP;
            cnt    <= SETUP_LD;
            cs_n   <= 1'b0;
            bus_a0 <= a0;
            d_out  <= is_read ? 8'h00 : data;
            d_oe   <= !is_read;
            rd_q   <= is_read;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            state <= ST_STROBE;
            cnt   <= STROBE_LD;
            wr_n  <= rd_q;
            rd_n  <= !rd_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            state <= ST_HOLD;
            cnt   <= HOLD_LD;
            wr_n  <= 1'b1;
            rd_n  <= 1'b1;
            // Read data is taken on the edge that releases rd_n.
            if (rd_q) rd_data <= d_in;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state <= ST_RECOVER;
            cs_n  <= 1'b1;
            d_oe  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pic_cpu_master.sv
// pic_cpu_master: host-side bus initiator for the 8259 PIC CPU port.
// Turns single-beat requests into timed PIC bus cycles and expands INIT
// into ICW1 -> ICW2 -> [ICW3] -> [ICW4].
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_op, req_data            operation and write byte
//   icw1..icw4                  INIT bytes, captured at accept
//   cs_n, wr_n, rd_n, a0        PIC bus control
//   d_out, d_oe, d_in           PIC data bus (tri-state resolved above)
//   rsp_valid, rsp_data, err    completion pulse, read byte, illegal-op flag
//   busy                        sequencer not idle
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while idle, so every
// transfer completes with exactly one rsp_valid pulse unless reset
// intervenes.
module pic_cpu_master
  import pic_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_data,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       err,
  output logic       busy
);

  seq_state_t seq_q;
  logic [2:0] op_q;
  logic       sngl_q;
  logic       ic4_q;
  logic [7:0] data_q;
  logic [7:0] icw2_q;
  logic [7:0] icw3_q;
  logic [7:0] icw4_q;
  logic [1:0] idx_q;
  logic       last_q;

  logic       accept;
  logic       start;
  logic       st_read;
  logic       st_a0;
  logic [7:0] st_data;
  logic [1:0] nxt_idx;
  logic       nxt_last;
  logic       op_is_read;

  logic       done;
  logic [7:0] rd_data;
  logic [2:0] phase;

  assign accept     = req_valid && req_ready;
  assign op_is_read = (op_q == OP_RD_A0) || (op_q == OP_RD_A1);

  // The first access launches straight from the request inputs on the
  // accept edge so SETUP is the very next cycle; later INIT accesses
  // launch from the captured bytes on the edge that ends RECOVER.
  always_comb begin
    start    = 1'b0;
    st_read  = 1'b0;
    st_a0    = 1'b0;
    st_data  = 8'h00;
    nxt_idx  = 2'd0;
    nxt_last = 1'b1;
    if (accept) begin
      case (req_op)
        OP_INIT: begin
          start              = 1'b1;
          st_data            = icw1;
          st_data[ICW1_FLAG] = 1'b1;
          nxt_last           = 1'b0;
        end
        OP_WR_A1: begin
          start   = 1'b1;
          st_a0   = 1'b1;
          st_data = req_data;
        end
        OP_WR_A0: begin
          start   = 1'b1;
          st_data = req_data;
        end
        OP_RD_A0: begin
          start   = 1'b1;
          st_read = 1'b1;
        end
        OP_RD_A1: begin
          start   = 1'b1;
          st_read = 1'b1;
          st_a0   = 1'b1;
        end
        default: start = 1'b0;
      endcase
    end else if (seq_q == SEQ_RUN && phase == ST_RECOVER && !last_q) begin
      start    = 1'b1;
      st_a0    = 1'b1;
      nxt_idx  = init_next_idx(idx_q, sngl_q);
      nxt_last = !init_has_next(nxt_idx, sngl_q, ic4_q);
      case (nxt_idx)
        2'd1:    st_data = icw2_q;
        2'd2:    st_data = icw3_q;
        default: st_data = icw4_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q     <= SEQ_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      op_q      <= '0;
      sngl_q    <= 1'b0;
      ic4_q     <= 1'b0;
      data_q    <= '0;
      icw2_q    <= '0;
      icw3_q    <= '0;
      icw4_q    <= '0;
      idx_q     <= '0;
      last_q    <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      if (start) begin
        idx_q  <= nxt_idx;
        last_q <= nxt_last;
      end
      case (seq_q)
        SEQ_IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            data_q    <= req_data;
            sngl_q    <= icw1[SNGL];
            ic4_q     <= icw1[IC4];
            icw2_q    <= icw2;
            icw3_q    <= icw3;
            icw4_q    <= icw4;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (start) begin
              seq_q <= SEQ_RUN;
            end else begin
              // Illegal op: no bus cycle, answer on the next cycle.
              seq_q     <= SEQ_ERR;
              rsp_valid <= 1'b1;
              err       <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        SEQ_RUN: begin
          // rsp_valid lands in the RECOVER cycle of the final access.
          if (done && last_q) begin
            rsp_valid <= 1'b1;
            if (op_is_read) rsp_data <= rd_data;
          end
          if (phase == ST_RECOVER && last_q) begin
            seq_q     <= SEQ_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        SEQ_ERR: begin
          seq_q     <= SEQ_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: seq_q <= SEQ_IDLE;
      endcase
    end
  end

  pic_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_bus (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .is_read(st_read),
    .a0     (st_a0),
    .data   (st_data),
    .d_in   (d_in),
    .cs_n   (cs_n),
    .wr_n   (wr_n),
    .rd_n   (rd_n),
    .bus_a0 (a0),
    .d_out  (d_out),
    .d_oe   (d_oe),
    .done   (done),
    .rd_data(rd_data),
    .phase  (phase)
  );

endmodule

// File: tb/tb_pic_cpu_master.sv
// tb_pic_cpu_master: directed self-checking bench for pic_cpu_master.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pic_cpu_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'b000;
  logic [7:0] req_data = 8'h00;
  logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00;
  logic       cs_n, wr_n, rd_n, a0, d_oe;
  logic [7:0] d_out;
  logic [7:0] d_in = 8'hFF;
  logic       rsp_valid, err, busy;
  logic [7:0] rsp_data;

  pic_cpu_master dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_data (req_data),
    .icw1     (icw1),
    .icw2     (icw2),
    .icw3     (icw3),
    .icw4     (icw4),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .rd_n     (rd_n),
    .a0       (a0),
    .d_out    (d_out),
    .d_oe     (d_oe),
    .d_in     (d_in),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .err      (err),
    .busy     (busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected and observed writes as {a0, data}
  logic [8:0] exp_q[$];
  logic [8:0] wr_q[$];
  logic       rd_a0_q[$];

  // Per-request observations filled by run_req
  int         wr_low, rd_low, cs_low, oe_bad, rsp_cyc, last_wait;
  logic       oe_seen, rsp_err, rdy_at_rsp;
  logic [7:0] rsp_dat;

  // Driver + bus monitor: issues one request and watches the bus until
  // rsp_valid (or a 40-cycle budget). Cycle 1 is the first cycle after
  // the accept edge. The bus model drives rd_val on d_in only during the
  // last cycle of the read strobe.
  task automatic run_req(input logic [2:0] op, input logic [7:0] data,
                         input logic [7:0] i1, input logic [7:0] i2,
                         input logic [7:0] i3, input logic [7:0] i4,
                         input logic [7:0] rd_val);
    logic prev_wr, prev_rd;
    int   rd_run;
    wr_q.delete(); rd_a0_q.delete();
    wr_low = 0; rd_low = 0; cs_low = 0; oe_bad = 0; rsp_cyc = 0;
    oe_seen = 1'b0; rsp_err = 1'b0; rdy_at_rsp = 1'bx; rsp_dat = 8'hxx;
    last_wait = 0;
    while (!req_ready && last_wait < 20) begin
      @(negedge clk);
      last_wait++;
    end
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL ready_before_req got %b want 1", req_ready);
    else n_pass++;
    req_op = op; req_data = data;
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
    req_valid = 1'b1;
    prev_wr = 1'b1; prev_rd = 1'b1; rd_run = 0;
    for (int c = 1; c <= 40 && rsp_cyc == 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (!wr_n) wr_low++;
      if (!rd_n) rd_low++;
      if (!cs_n) cs_low++;
      if (d_oe) oe_seen = 1'b1;
      if (!wr_n && !d_oe) oe_bad++;
      if (!wr_n && prev_wr) wr_q.push_back({a0, d_out});
      if (!rd_n && prev_rd) rd_a0_q.push_back(a0);
      prev_wr = wr_n; prev_rd = rd_n;
      if (!rd_n) rd_run++; else rd_run = 0;
      d_in = (!rd_n && rd_run == 2) ? rd_val : 8'hFF;
      if (rsp_valid) begin
        rsp_cyc = c; rsp_err = err; rsp_dat = rsp_data; rdy_at_rsp = req_ready;
      end
    end
    d_in = 8'hFF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cs_n !== 1'b1) $display("FAIL rst_cs_n got %b want 1", cs_n); else n_pass++;
    n_checks++; if (wr_n !== 1'b1) $display("FAIL rst_wr_n got %b want 1", wr_n); else n_pass++;
    n_checks++; if (rd_n !== 1'b1) $display("FAIL rst_rd_n got %b want 1", rd_n); else n_pass++;
    n_checks++; if (a0 !== 1'b0) $display("FAIL rst_a0 got %b want 0", a0); else n_pass++;
    n_checks++; if (d_out !== 8'h00) $display("FAIL rst_d_out got %h want 00", d_out); else n_pass++;
    n_checks++; if (d_oe !== 1'b0) $display("FAIL rst_d_oe got %b want 0", d_oe); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 8'h00) $display("FAIL rst_rsp_data got %h want 00", rsp_data); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_init_no_icw3();
    logic [8:0] exp, got;
    exp_q.push_back({1'b0, 8'h13});
    exp_q.push_back({1'b1, 8'h20});
    exp_q.push_back({1'b1, 8'h01});
    run_req(3'b000, 8'h00, 8'h13, 8'h20, 8'h77, 8'h01, 8'h00);
    n_checks++; if (wr_q.size() !== 3) $display("FAIL init3_count got %0d want 3", wr_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = 'x;
      if (wr_q.size() > 0) got = wr_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL init3_write got %h want %h", got, exp); else n_pass++;
    end
    n_checks++; if (rsp_cyc !== 15) $display("FAIL init3_rsp_cycle got %0d want 15", rsp_cyc); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL init3_err got %b want 0", rsp_err); else n_pass++;
    n_checks++; if (wr_low !== 6) $display("FAIL init3_wr_low got %0d want 6", wr_low); else n_pass++;
    n_checks++; if (oe_bad !== 0) $display("FAIL init3_oe_during_wr got %0d want 0", oe_bad); else n_pass++;
  endtask

  task automatic test_init_full();
    logic [8:0] exp, got;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h08});
    exp_q.push_back({1'b1, 8'h04});
    exp_q.push_back({1'b1, 8'h1D});
    run_req(3'b000, 8'h00, 8'h01, 8'h08, 8'h04, 8'h1D, 8'h00);
    n_checks++; if (wr_q.size() !== 4) $display("FAIL init4_count got %0d want 4", wr_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = 'x;
      if (wr_q.size() > 0) got = wr_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL init4_write got %h want %h", got, exp); else n_pass++;
    end
    n_checks++; if (rsp_cyc !== 20) $display("FAIL init4_rsp_cycle got %0d want 20", rsp_cyc); else n_pass++;
  endtask

  // Single mode without ICW4: only ICW1 and ICW2 go out.
  task automatic test_init_min();
    logic [8:0] exp, got;
    exp_q.push_back({1'b0, 8'h12});
    exp_q.push_back({1'b1, 8'h40});
    run_req(3'b000, 8'h00, 8'h02, 8'h40, 8'h55, 8'h66, 8'h00);
    n_checks++; if (wr_q.size() !== 2) $display("FAIL init2_count got %0d want 2", wr_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front(); got = 'x;
      if (wr_q.size() > 0) got = wr_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL init2_write got %h want %h", got, exp); else n_pass++;
    end
    n_checks++; if (rsp_cyc !== 10) $display("FAIL init2_rsp_cycle got %0d want 10", rsp_cyc); else n_pass++;
  endtask

  task automatic test_wr_a1();
    logic [8:0] got;
    run_req(3'b001, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    got = 'x;
    if (wr_q.size() > 0) got = wr_q.pop_front();
    n_checks++; if (got !== {1'b1, 8'hFE}) $display("FAIL wr_a1_write got %h want 1fe", got); else n_pass++;
    n_checks++; if (wr_q.size() !== 0) $display("FAIL wr_a1_extra got %0d want 0", wr_q.size()); else n_pass++;
    n_checks++; if (wr_low !== 2) $display("FAIL wr_a1_wr_low got %0d want 2", wr_low); else n_pass++;
    n_checks++; if (cs_low !== 4) $display("FAIL wr_a1_cs_low got %0d want 4", cs_low); else n_pass++;
    n_checks++; if (oe_seen !== 1'b1) $display("FAIL wr_a1_oe got %b want 1", oe_seen); else n_pass++;
    n_checks++; if (rsp_cyc !== 5) $display("FAIL wr_a1_rsp_cycle got %0d want 5", rsp_cyc); else n_pass++;
  endtask

  task automatic test_rd_a1();
    logic got_a0;
    run_req(3'b100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A);
    got_a0 = 1'bx;
    if (rd_a0_q.size() > 0) got_a0 = rd_a0_q.pop_front();
    n_checks++; if (got_a0 !== 1'b1) $display("FAIL rd_a1_a0 got %b want 1", got_a0); else n_pass++;
    n_checks++; if (rd_low !== 2) $display("FAIL rd_a1_rd_low got %0d want 2", rd_low); else n_pass++;
    n_checks++; if (oe_seen !== 1'b0) $display("FAIL rd_a1_oe got %b want 0", oe_seen); else n_pass++;
    n_checks++; if (wr_low !== 0) $display("FAIL rd_a1_wr_low got %0d want 0", wr_low); else n_pass++;
    n_checks++; if (rsp_dat !== 8'h5A) $display("FAIL rd_a1_data got %h want 5a", rsp_dat); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL rd_a1_err got %b want 0", rsp_err); else n_pass++;
    n_checks++; if (rsp_cyc !== 5) $display("FAIL rd_a1_rsp_cycle got %0d want 5", rsp_cyc); else n_pass++;
  endtask

  task automatic test_illegal();
    run_req(3'b111, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    n_checks++; if (rsp_cyc !== 1) $display("FAIL ill7_rsp_cycle got %0d want 1", rsp_cyc); else n_pass++;
    n_checks++; if (rsp_err !== 1'b1) $display("FAIL ill7_err got %b want 1", rsp_err); else n_pass++;
    n_checks++; if (cs_low !== 0) $display("FAIL ill7_cs_low got %0d want 0", cs_low); else n_pass++;
    run_req(3'b101, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    n_checks++; if (rsp_cyc !== 1) $display("FAIL ill5_rsp_cycle got %0d want 1", rsp_cyc); else n_pass++;
    n_checks++; if (rsp_err !== 1'b1) $display("FAIL ill5_err got %b want 1", rsp_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic got_a0;
    run_req(3'b011, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5);
    got_a0 = 1'bx;
    if (rd_a0_q.size() > 0) got_a0 = rd_a0_q.pop_front();
    n_checks++; if (got_a0 !== 1'b0) $display("FAIL rd_a0_a0 got %b want 0", got_a0); else n_pass++;
    n_checks++; if (rsp_dat !== 8'hA5) $display("FAIL rd_a0_data got %h want a5", rsp_dat); else n_pass++;
    n_checks++; if (rdy_at_rsp !== 1'b0) $display("FAIL b2b_ready_at_rsp got %b want 0", rdy_at_rsp); else n_pass++;
    run_req(3'b001, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    n_checks++; if (last_wait !== 1) $display("FAIL b2b_idle_gap got %0d want 1", last_wait); else n_pass++;
    n_checks++; if (rsp_cyc !== 5) $display("FAIL b2b_wr_rsp_cycle got %0d want 5", rsp_cyc); else n_pass++;
    n_checks++; if (rsp_data !== 8'hA5) $display("FAIL b2b_rsp_data_hold got %h want a5", rsp_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [8:0] got;
    int rsp_seen, cs_seen;
    rsp_seen = 0; cs_seen = 0;
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
    req_op = 3'b000; icw1 = 8'h13; icw2 = 8'h20; icw3 = 8'h00; icw4 = 8'h01;
    req_valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) rsp_seen++;
    end
    // Cycle 7 is the first STROBE cycle of ICW2.
    n_checks++; if (wr_n !== 1'b0) $display("FAIL mid_strobe_wr_n got %b want 0", wr_n); else n_pass++;
    n_checks++; if (d_out !== 8'h20) $display("FAIL mid_strobe_d_out got %h want 20", d_out); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (wr_n !== 1'b1) $display("FAIL mid_rst_wr_n got %b want 1", wr_n); else n_pass++;
    n_checks++; if (cs_n !== 1'b1) $display("FAIL mid_rst_cs_n got %b want 1", cs_n); else n_pass++;
    n_checks++; if (d_oe !== 1'b0) $display("FAIL mid_rst_d_oe got %b want 0", d_oe); else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
      if (!cs_n) cs_seen++;
    end
    n_checks++; if (rsp_seen !== 0) $display("FAIL mid_rst_no_rsp got %0d want 0", rsp_seen); else n_pass++;
    n_checks++; if (cs_seen !== 0) $display("FAIL mid_rst_bus_quiet got %0d want 0", cs_seen); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else n_pass++;
    run_req(3'b010, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    got = 'x;
    if (wr_q.size() > 0) got = wr_q.pop_front();
    n_checks++; if (got !== {1'b0, 8'h0B}) $display("FAIL post_rst_wr_a0 got %h want 00b", got); else n_pass++;
    n_checks++; if (rsp_cyc !== 5) $display("FAIL post_rst_rsp_cycle got %0d want 5", rsp_cyc); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL post_rst_err got %b want 0", rsp_err); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init_no_icw3();
    test_init_full();
    test_init_min();
    test_wr_a1();
    test_rd_a1();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
